// File: rtl/sobel_gcd_spi_pkg.sv
// Shared definitions for the sobel_gcd SPI initiator and its target:
// FSM state encoding, byte width and command opcodes.
package sobel_gcd_spi_pkg;

    localparam int SPI_BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOAD,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } spi_state_t;

    // Opcodes understood by the sobel_gcd target; first byte of a frame.
    localparam logic [SPI_BYTE_W-1:0] CMD_GCD_WR_A = 8'h01;
    localparam logic [SPI_BYTE_W-1:0] CMD_GCD_WR_B = 8'h02;
    localparam logic [SPI_BYTE_W-1:0] CMD_GCD_RD   = 8'h03;
    localparam logic [SPI_BYTE_W-1:0] CMD_SOBEL_PX = 8'h10;

endpackage

// File: rtl/sobel_gcd_spi_master_sck_tick_gen.sv
// Half-period counter for the SPI initiator: emits a tick every CLK_DIV cycles
// and, when toggling is enabled, flips SCK with matching rise/fall strobes.
module spi_sck_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic nreset,
    input  logic en,
    input  logic toggle_en,
    output logic tick,
    output logic rise,
    output logic fall,
    output logic sck
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt_reg;
    logic             sck_reg;

    assign tick = en && (cnt_reg == CNT_W'(CLK_DIV - 1));
    // Strobes fire on the cycle before SCK changes, so the edge and the
    // registered action triggered by the strobe land on the same clk edge.
    assign rise = tick && toggle_en && !sck_reg;
    assign fall = tick && toggle_en && sck_reg;
    assign sck  = sck_reg;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt_reg <= '0;
            sck_reg <= 1'b0;
        end else if (!en) begin
            cnt_reg <= '0;
            sck_reg <= 1'b0;
        end else begin
            cnt_reg <= tick ? '0 : cnt_reg + CNT_W'(1);
            if (tick && toggle_en) begin
                sck_reg <= ~sck_reg;
            end
        end
    end

endmodule

// File: rtl/sobel_gcd_spi_master.sv
// SPI mode-0 initiator turning a valid/ready byte stream into CS-framed transfers.
// Define SOBEL_GCD_SPI_MISO_SYNC_EN to add a 2-flop MISO synchronizer (needs CLK_DIV>=3).
module sobel_gcd_spi_master
    import sobel_gcd_spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int LEN_W   = 4
) (
    input  logic                  clk_i,
    input  logic                  nreset_i,
    input  logic                  start_i,
    input  logic [LEN_W-1:0]      len_i,
    input  logic [SPI_BYTE_W-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic [SPI_BYTE_W-1:0] rx_data_o,
    output logic                  rx_valid_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  spi_sck_o,
    output logic                  spi_cs_o,
    output logic                  spi_sdo_o,
    input  logic                  spi_sdi_i
);

    spi_state_t state_reg, state_next;

    logic                  tick, rise, fall, sck;
    logic                  tick_en, toggle_en, cs_next, handshake;
    logic                  sample_en, sample_bit;
    logic [LEN_W-1:0]      count_reg;
    logic [2:0]            bit_reg;
    logic [SPI_BYTE_W-2:0] tx_rest_reg;
    logic [SPI_BYTE_W-1:0] rx_shift_reg, rx_data_reg;
    logic                  sdo_reg, cs_reg, rx_valid_reg, zero_done_reg;

    spi_sck_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
        .clk       (clk_i),
        .nreset    (nreset_i),
        .en        (tick_en),
        .toggle_en (toggle_en),
        .tick      (tick),
        .rise      (rise),
        .fall      (fall),
        .sck       (sck)
    );

`ifdef SOBEL_GCD_SPI_MISO_SYNC_EN
    logic [1:0] sync_reg, rise_dly_reg;

    if (CLK_DIV < 3) begin : g_clk_div_check
        $error("MISO synchronizer needs CLK_DIV >= 3");
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            sync_reg     <= '0;
            rise_dly_reg <= '0;
        end else begin
            sync_reg     <= {sync_reg[0], spi_sdi_i};
            rise_dly_reg <= {rise_dly_reg[0], rise};
        end
    end

    assign sample_en  = rise_dly_reg[1];
    assign sample_bit = sync_reg[1];
`else
    assign sample_en  = rise;
    assign sample_bit = spi_sdi_i;
`endif

    // The ready window opens one cycle after the previous byte's rx pulse,
    // so a byte's rx_valid_o never lands on the next byte's handshake.
    assign tx_ready_o = (state_reg == ST_LOAD) && !rx_valid_reg;
    assign handshake  = tx_ready_o && tx_valid_i;
    assign busy_o     = (state_reg != ST_IDLE);
    assign done_o     = zero_done_reg || ((state_reg == ST_GAP) && tick);
    assign rx_data_o  = rx_data_reg;
    assign rx_valid_o = rx_valid_reg;
    assign spi_sck_o  = sck;
    assign spi_cs_o   = cs_reg;
    assign spi_sdo_o  = sdo_reg;

    always_comb begin
        state_next = state_reg;
        tick_en    = 1'b0;
        toggle_en  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start_i && (len_i != '0)) state_next = ST_SETUP;
            end
            ST_SETUP: begin
                tick_en = 1'b1;
                if (tick) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (handshake) state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                tick_en   = 1'b1;
                toggle_en = 1'b1;
                if (fall && (bit_reg == 3'd7)) begin
                    state_next = (count_reg == LEN_W'(1)) ? ST_HOLD : ST_LOAD;
                end
            end
            ST_HOLD: begin
                tick_en = 1'b1;
                if (tick) state_next = ST_GAP;
            end
            ST_GAP: begin
                tick_en = 1'b1;
                if (tick) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        cs_next = !((state_next == ST_SETUP) || (state_next == ST_LOAD) ||
                    (state_next == ST_SHIFT) || (state_next == ST_HOLD));
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_reg     <= ST_IDLE;
            cs_reg        <= 1'b1;
            sdo_reg       <= 1'b0;
            rx_valid_reg  <= 1'b0;
            zero_done_reg <= 1'b0;
            count_reg     <= '0;
            bit_reg       <= '0;
            tx_rest_reg   <= '0;
            rx_shift_reg  <= '0;
            rx_data_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            cs_reg        <= cs_next;
            rx_valid_reg  <= 1'b0;
            zero_done_reg <= (state_reg == ST_IDLE) && start_i && (len_i == '0);
            if (sample_en) begin
                rx_shift_reg <= {rx_shift_reg[SPI_BYTE_W-2:0], sample_bit};
            end
            case (state_reg)
                ST_IDLE: begin
                    sdo_reg <= 1'b0;
                    if (start_i) count_reg <= len_i;
                end
                ST_LOAD: begin
                    if (handshake) begin
                        tx_rest_reg <= tx_data_i[SPI_BYTE_W-2:0];
                        sdo_reg     <= tx_data_i[SPI_BYTE_W-1];
                        bit_reg     <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (fall) begin
                        if (bit_reg == 3'd7) begin
                            rx_data_reg  <= rx_shift_reg;
                            rx_valid_reg <= 1'b1;
                            count_reg    <= count_reg - LEN_W'(1);
                        end else begin
                            bit_reg     <= bit_reg + 3'd1;
                            sdo_reg     <= tx_rest_reg[SPI_BYTE_W-2];
                            tx_rest_reg <= {tx_rest_reg[SPI_BYTE_W-3:0], 1'b0};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_gcd_spi_master.sv
// Bench for sobel_gcd_spi_master: behavioural SPI target plus frame-level reference checks.
module tb_sobel_gcd_spi_master;

    localparam int CLK_DIV = 2;
    localparam int LEN_W   = 4;

    logic             clk = 1'b0;
    logic             nreset_i = 1'b0;
    logic             start_i = 1'b0;
    logic [LEN_W-1:0] len_i = '0;
    logic [7:0]       tx_data_i = '0;
    logic             tx_valid_i = 1'b0;
    logic             tx_ready_o, rx_valid_o, busy_o, done_o;
    logic [7:0]       rx_data_o;
    logic             spi_sck_o, spi_cs_o, spi_sdo_o, spi_sdi_i;

    sobel_gcd_spi_master #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
        .clk_i      (clk),
        .nreset_i   (nreset_i),
        .start_i    (start_i),
        .len_i      (len_i),
        .tx_data_i  (tx_data_i),
        .tx_valid_i (tx_valid_i),
        .tx_ready_o (tx_ready_o),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .spi_sck_o  (spi_sck_o),
        .spi_cs_o   (spi_cs_o),
        .spi_sdo_o  (spi_sdo_o),
        .spi_sdi_i  (spi_sdi_i)
    );

    always #5 clk = ~clk;

    int cmps = 0;
    int errs = 0;

    logic [7:0] tx_bytes [0:15];
    logic [7:0] resp     [0:15];

    // Monitors: free-running counters, read by the stimulus as deltas.
    int   rise_total = 0, rise_cs_high = 0, cs_rise = 0;
    int   sck_falls = 0, falls_base = 0;
    int   busy_cyc = 0, rx_cnt = 0, done_cnt = 0, ready_rise = 0;
    logic ready_prev = 1'b0;
    logic       mosi_bits [0:4095];
    logic [7:0] rx_hist   [0:255];

    always @(posedge spi_sck_o) begin
        mosi_bits[rise_total % 4096] = spi_sdo_o;
        rise_total++;
        if (spi_cs_o) rise_cs_high++;
    end
    always @(posedge spi_cs_o) cs_rise++;
    always @(negedge spi_sck_o) sck_falls++;
    always @(negedge spi_cs_o) falls_base = sck_falls;

    // Mode-0 target: bit k of the frame is presented after k SCK falls, MSB first.
    int         tgt_idx;
    logic [7:0] tgt_cur;
    always_comb begin
        tgt_idx   = sck_falls - falls_base;
        tgt_cur   = resp[(tgt_idx / 8) % 16];
        spi_sdi_i = tgt_cur[7 - (tgt_idx % 8)];
    end

    always @(negedge clk) begin
        if (busy_o) busy_cyc++;
        if (rx_valid_o) begin
            rx_hist[rx_cnt % 256] = rx_data_o;
            rx_cnt++;
        end
        if (done_o) done_cnt++;
        if (tx_ready_o && !ready_prev) ready_rise++;
        ready_prev = tx_ready_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmps++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(output int waited);
        waited = 0;
        while (tx_ready_o !== 1'b1 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
    endtask

    // One framed transfer of n bytes from tx_bytes, target answering with resp.
    task automatic run_frame(input string tag, input int n, input int stall_idx,
                             input int stall_cyc, input int exp_busy);
        int r0, rx0, d0, b0, c0, rr0, waited, stall_bad;
        logic [7:0] ob;
        r0 = rise_total; rx0 = rx_cnt; d0 = done_cnt; b0 = busy_cyc;
        c0 = cs_rise; rr0 = ready_rise; stall_bad = 0;
        @(negedge clk);
        start_i = 1'b1;
        len_i   = LEN_W'(n);
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == stall_idx) begin
                tx_valid_i = 1'b0;
                wait_ready(waited);
                repeat (stall_cyc) begin
                    @(negedge clk);
                    if (spi_sck_o !== 1'b0 || spi_cs_o !== 1'b0 || tx_ready_o !== 1'b1) stall_bad++;
                end
                check({tag, " stall_lines_idle"}, stall_bad, 0);
            end
            tx_valid_i = 1'b1;
            tx_data_i  = tx_bytes[i];
            wait_ready(waited);
            check({tag, " tx_ready_timeout"}, 32'(waited >= 400), 0);
            @(negedge clk);
        end
        tx_valid_i = 1'b0;
        waited = 0;
        while (done_o !== 1'b1 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        check({tag, " done_timeout"}, 32'(waited >= 400), 0);
        repeat (4) @(negedge clk);
        check({tag, " sck_rises"}, rise_total - r0, 8 * n);
        check({tag, " cs_frames"}, cs_rise - c0, 1);
        check({tag, " done_pulses"}, done_cnt - d0, 1);
        check({tag, " rx_pulses"}, rx_cnt - rx0, n);
        check({tag, " tx_ready_windows"}, ready_rise - rr0, n);
        if (exp_busy >= 0) check({tag, " busy_cycles"}, busy_cyc - b0, exp_busy);
        for (int i = 0; i < n; i++) begin
            ob = '0;
            for (int j = 0; j < 8; j++) ob = {ob[6:0], mosi_bits[(r0 + 8 * i + j) % 4096]};
            check($sformatf("%s mosi_byte%0d", tag, i), ob, tx_bytes[i]);
            check($sformatf("%s rx_byte%0d", tag, i), rx_hist[(rx0 + i) % 256], resp[i]);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, d0, c0, rx0, waited, n;
        for (int i = 0; i < 16; i++) begin
            resp[i]     = 8'h00;
            tx_bytes[i] = 8'h00;
        end

        // Reset values
        repeat (3) @(negedge clk);
        check("rst spi_cs_o", spi_cs_o, 1);
        check("rst spi_sck_o", spi_sck_o, 0);
        check("rst spi_sdo_o", spi_sdo_o, 0);
        check("rst tx_ready_o", tx_ready_o, 0);
        check("rst rx_valid_o", rx_valid_o, 0);
        check("rst rx_data_o", rx_data_o, 8'h00);
        check("rst busy_o", busy_o, 0);
        check("rst done_o", done_o, 0);
        nreset_i = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte: A5 out, 3C back, 19*CLK_DIV+1 busy cycles
        tx_bytes[0] = 8'hA5;
        resp[0]     = 8'h3C;
        run_frame("single", 1, -1, 0, 19 * CLK_DIV + 1);
        check("single rx_data_o_held", rx_data_o, 8'h3C);
        check("single sdo_idle", spi_sdo_o, 0);

        // Three-byte frame
        tx_bytes[0] = 8'h01; tx_bytes[1] = 8'h30; tx_bytes[2] = 8'h12;
        for (int i = 0; i < 3; i++) resp[i] = 8'($urandom);
        run_frame("three", 3, -1, 0, -1);

        // Underrun before byte 2
        for (int i = 0; i < 3; i++) begin
            tx_bytes[i] = 8'($urandom);
            resp[i]     = 8'($urandom);
        end
        run_frame("underrun", 3, 1, 20, -1);

        // Zero-length request
        r0 = rise_total; d0 = done_cnt; c0 = cs_rise;
        @(negedge clk);
        start_i = 1'b1;
        len_i   = '0;
        @(negedge clk);
        start_i = 1'b0;
        check("zero done_next_cycle", done_o, 1);
        check("zero busy_low", busy_o, 0);
        check("zero cs_high", spi_cs_o, 1);
        @(negedge clk);
        check("zero done_one_cycle", done_o, 0);
        repeat (5) @(negedge clk);
        check("zero sck_rises", rise_total - r0, 0);
        check("zero cs_activity", cs_rise - c0, 0);
        check("zero done_pulses", done_cnt - d0, 1);

        // Reset during bit 4 of byte 1
        r0 = rise_total; d0 = done_cnt;
        tx_bytes[0] = 8'($urandom);
        @(negedge clk);
        start_i = 1'b1;
        len_i   = LEN_W'(2);
        @(negedge clk);
        start_i    = 1'b0;
        tx_valid_i = 1'b1;
        tx_data_i  = tx_bytes[0];
        wait_ready(waited);
        @(negedge clk);
        tx_valid_i = 1'b0;
        waited = 0;
        while ((rise_total - r0) < 4 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        check("rstmid reach_bit4_timeout", 32'(waited >= 400), 0);
        #2 nreset_i = 1'b0;
        #1;
        check("rstmid cs_high_now", spi_cs_o, 1);
        check("rstmid sck_low_now", spi_sck_o, 0);
        check("rstmid busy_low_now", busy_o, 0);
        @(negedge clk);
        nreset_i = 1'b1;
        repeat (10) @(negedge clk);
        check("rstmid no_done", done_cnt - d0, 0);
        for (int i = 0; i < 2; i++) begin
            tx_bytes[i] = 8'($urandom);
            resp[i]     = 8'($urandom);
        end
        run_frame("post_reset", 2, -1, 0, -1);

        // start_i while busy, and on the frame-end done cycle
        r0 = rise_total; d0 = done_cnt; c0 = cs_rise; rx0 = rx_cnt;
        tx_bytes[0] = 8'($urandom);
        resp[0]     = 8'($urandom);
        @(negedge clk);
        start_i = 1'b1;
        len_i   = LEN_W'(1);
        @(negedge clk);
        start_i    = 1'b0;
        tx_valid_i = 1'b1;
        tx_data_i  = tx_bytes[0];
        wait_ready(waited);
        @(negedge clk);
        tx_valid_i = 1'b0;
        waited = 0;
        while ((rise_total - r0) < 2 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        start_i = 1'b1;
        len_i   = LEN_W'(3);
        @(negedge clk);
        start_i = 1'b0;
        waited = 0;
        while (done_o !== 1'b1 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        check("busystart done_timeout", 32'(waited >= 400), 0);
        start_i = 1'b1;
        len_i   = LEN_W'(1);
        @(negedge clk);
        start_i = 1'b0;
        repeat (10) @(negedge clk);
        check("busystart idle_after", busy_o, 0);
        check("busystart cs_frames", cs_rise - c0, 1);
        check("busystart sck_rises", rise_total - r0, 8);
        check("busystart done_pulses", done_cnt - d0, 1);
        check("busystart rx_byte", rx_hist[rx0 % 256], resp[0]);

        // Randomised frames with random stalls
        for (int k = 0; k < 4; k++) begin
            n = int'($urandom_range(1, 4));
            for (int i = 0; i < n; i++) begin
                tx_bytes[i] = 8'($urandom);
                resp[i]     = 8'($urandom);
            end
            run_frame($sformatf("rand%0d", k), n, int'($urandom_range(0, 3)),
                      int'($urandom_range(1, 8)), -1);
        end

        check("global no_sck_while_cs_high", rise_cs_high, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

endmodule

// File: doc/sobel_gcd_spi_master.md
Name: sobel_gcd_spi_master

Overview:
- SPI mode-0 initiator that drives the sobel_gcd SPI target (sck/sdi/cs in, sdo out) from the controller side.
- Used as an on-chip bring-up/loopback driver and as the synthesizable stimulus engine in the system bench.
- Converts a byte-stream valid/ready interface into framed SPI transactions:
  - CS low for the whole frame.
  - MSB first.
  - MOSI launched on SCK falling edge; MISO sampled on SCK rising edge.

Parameters:
- CLK_DIV, 4, clk_i cycles per SCK half-period; legal values >= 2.
- LEN_W, 4, width of the frame byte-count input; maximum frame is 2**LEN_W-1 bytes.

Ports:
- clk_i  in  1  system clock
- nreset_i  in  1  reset, asynchronous assert, active-low
- start_i  in  1  frame request; sampled only while busy_o=0
- len_i  in  LEN_W  bytes in frame; latched on accepted start_i
- tx_data_i  in  8  next byte to transmit
- tx_valid_i  in  1  tx_data_i valid
- tx_ready_o  out  1  master can take a byte (LOAD state)
- rx_data_o  out  8  last byte received from target
- rx_valid_o  out  1  one-cycle pulse; rx_data_o updated
- busy_o  out  1  frame in progress
- done_o  out  1  one-cycle pulse at frame end
- spi_sck_o  out  1  SPI clock, idle low
- spi_cs_o  out  1  chip select, active low, idle high
- spi_sdo_o  out  1  MOSI
- spi_sdi_i  in  1  MISO

Behaviour:
- Reset values: spi_cs_o=1, spi_sck_o=0, spi_sdo_o=0, tx_ready_o=0, rx_valid_o=0, rx_data_o=8'h00, busy_o=0, done_o=0; FSM in IDLE.
- Reset mid-frame: CS deasserts and SCK drops immediately (asynchronous); no done_o.
- FSM states: IDLE, SETUP, LOAD, SHIFT, HOLD, GAP.
- IDLE:
  - start_i=1 and len_i!=0: latch len_i; busy_o=1; go to SETUP.
  - start_i=1 and len_i==0: no CS activity; done_o pulses on the next cycle; busy_o stays 0.
- SETUP: CS low for CLK_DIV cycles, then LOAD.
- LOAD:
  - tx_ready_o=1.
  - On tx_valid_i & tx_ready_o: load shift register; spi_sdo_o=bit7; go to SHIFT.
  - Underrun (tx_valid_i=0): stay in LOAD indefinitely with SCK low and CS low.
- SHIFT:
  - 8 bits, each bit = CLK_DIV cycles SCK low followed by CLK_DIV cycles SCK high.
  - Rising edge: shift spi_sdi_i into the rx register LSB.
  - Falling edge: advance spi_sdo_o to the next bit.
  - After the 8th high half, SCK returns low and rx_valid_o pulses with the full byte; remaining count decrements.
  - Count>0: go to LOAD. Count==0: go to HOLD.
- HOLD: CS stays low, SCK low, for CLK_DIV cycles; then CS high and go to GAP.
- GAP: CS high for CLK_DIV cycles; on the last cycle done_o=1; next cycle IDLE with busy_o=0.
- start_i while busy_o=1: ignored, with no queuing.
- Single-byte frame latency without stall: busy_o high for 19*CLK_DIV+1 cycles.
- Exactly 8*len SCK rising edges per frame; no SCK edge while CS is high.
- spi_sdo_o holds its last bit between bytes and returns to 0 in IDLE.
- Simultaneous events:
  - rx_valid_o of byte n and tx handshake of byte n+1 never coincide; LOAD follows the rx pulse by one cycle.
  - Frame-end done_o and a new start_i in the same cycle: start_i is ignored.

Optional Feature:
- Macro: SOBEL_GCD_SPI_MISO_SYNC_EN.
- Defined:
  - spi_sdi_i passes through a 2-flop synchronizer.
  - Each rx bit is sampled 2 clk_i cycles after the SCK rising edge, still inside the high half; requires CLK_DIV>=3 (checked by elaboration-time assertion).
  - Output timing is unchanged.
- Undefined: spi_sdi_i is sampled directly on the cycle SCK rises.

Decomposition:
- Package sobel_gcd_spi_pkg:
  - FSM state enum.
  - SPI_BYTE_W=8.
  - Command opcodes shared with the target (CMD_GCD_WR_A, CMD_GCD_WR_B, CMD_GCD_RD, CMD_SOBEL_PX), so bench and target agree.
- Sub-module spi_sck_tick_gen: CLK_DIV half-period counter producing rise/fall tick strobes plus the SCK level. It is enabled by the FSM in SETUP/SHIFT/HOLD/GAP and cleared in IDLE and LOAD.

Test Plan:
- Single byte. Setup: CLK_DIV=2, len=1, tx=8'hA5, target model returns 8'h3C. Required: MOSI bits 1,0,1,0,0,1,0,1 at the 8 rising edges; rx_data_o=8'h3C with one rx_valid_o pulse; busy_o high 39 cycles; one done_o pulse.
- Three-byte frame. Stimulus: tx 8'h01, 8'h30, 8'h12. Required: CS low continuously; 24 rising edges; three rx_valid_o pulses; tx_ready_o asserted three times.
- Underrun. Stimulus: tx_valid_i withheld 20 cycles before byte 2. Required: SCK low and CS low throughout the stall; frame resumes correctly; bit count unaffected.
- Zero length. Stimulus: len_i=0 with start_i. Required: CS never falls; done_o pulses the next cycle; no SCK edges.
- Reset mid-frame. Stimulus: nreset_i low during bit 4. Required: spi_cs_o=1 and spi_sck_o=0 in the same cycle; no done_o; a new frame after reset is clean.
- Busy start. Stimulus: start_i pulsed during SHIFT and again on the done_o cycle. Required: both ignored; no second frame starts.
